key_action_gen: RTL and testbench
=================================

Name: key_action_gen

Overview:
- Sits between the PS/2 keyboard decoder and the game logic.
- Converts raw key events (key_down bitmap, last_change code, key_valid strobe) into single-cycle game action pulses.
- Provides DAS/ARR auto-repeat for horizontal moves, plus a pause toggle level.
- Runs entirely on the 100 MHz system clock, the same clock as the decoder.

Parameters:
DAS_CYCLES, 17000000, hold time from first move pulse to first repeat pulse (170 ms).
ARR_CYCLES, 5000000, period between repeat pulses once repeating (50 ms).
SOFT_CYCLES, 3000000, soft-drop repeat period (used only with the optional feature).
CNT_W, 25, counter width; must satisfy 2^CNT_W > max(DAS_CYCLES, ARR_CYCLES, SOFT_CYCLES).

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
key_down  in  512  decoder held-key bitmap, indexed by 9-bit extended scan code
last_change  in  9  code of the most recent make/break event
key_valid  in  1  one-cycle strobe: last_change/key_down just updated
mv_left  out  1  one-cycle pulse: move piece left
mv_right  out  1  one-cycle pulse: move piece right
soft_drop  out  1  one-cycle pulse: move piece down one row
hard_drop  out  1  one-cycle pulse: drop piece
rot_cw  out  1  one-cycle pulse: rotate clockwise
rot_ccw  out  1  one-cycle pulse: rotate counter-clockwise
paused  out  1  level: game paused

Behaviour:
- Key codes: LEFT 9'h16B, RIGHT 9'h174, DOWN 9'h172, UP (rot_cw) 9'h175, Z (rot_ccw) 9'h01A, SPACE (hard_drop) 9'h029, P (pause) 9'h04D.
- Press event: key_valid=1 and key_down[last_change]=1. Release event: key_valid=1 and key_down[last_change]=0.
- All outputs are registered. Reset: every pulse output 0, paused=0, horizontal FSM in H_IDLE, all counters 0.
- Latency: an event sampled at edge t produces its pulse high during cycle t+1, for exactly one cycle.
- Edge-only actions: UP, Z and SPACE each give one pulse per press event. No repeat. A release event does nothing.
- Pause: a P press event toggles paused.
  - While paused=1, all pulse outputs are forced 0, the horizontal FSM is held in H_IDLE and the soft-drop counter is cleared.
  - Held arrow keys do not resume repeating on unpause. A fresh press is required.
- Horizontal FSM. States: H_IDLE, H_DAS, H_ARR. Registers: dir (0=left, 1=right) and cnt.
  - H_IDLE, LEFT or RIGHT press: pulse that direction, set dir, cnt<=0, go to H_DAS.
  - H_DAS: cnt increments each cycle. When cnt==DAS_CYCLES-1: pulse dir, cnt<=0, go to H_ARR.
  - H_ARR: when cnt==ARR_CYCLES-1: pulse dir, cnt<=0.
  - First repeat pulse therefore comes DAS_CYCLES cycles after the initial pulse. Later pulses are spaced ARR_CYCLES apart.
  - Opposite-direction press in H_DAS or H_ARR: last press wins. Pulse the new direction, set dir, cnt<=0, go to H_DAS.
  - Active key released (release event, or key_down[active code]==0 in any cycle):
    - if the opposite key is still held, switch dir, pulse it, cnt<=0, go to H_DAS;
    - otherwise go to H_IDLE with no pulse.
  - Release of the inactive key: no effect.
  - Release check takes priority over a repeat pulse due in the same cycle. No pulse is issued after release.
  - mv_left and mv_right are never high in the same cycle.
- Soft drop (feature off): one soft_drop pulse per DOWN press event.
- Independence: different keys are tracked independently. One press event per cycle at most, set by the decoder. A horizontal repeat pulse may coincide with a rot/hard_drop/soft_drop pulse, and all are issued.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). No pulse is emitted on deassertion, even if keys are held.

Optional Feature:
- Macro: KEY_ACTION_SOFT_REPEAT_EN.
- Defined: DOWN press pulses soft_drop immediately (t+1). A dedicated counter then pulses soft_drop every SOFT_CYCLES while key_down[9'h172]=1. No DAS delay. Releasing DOWN clears the counter, and a pulse due that same cycle is suppressed.
- Undefined: single pulse per DOWN press. No soft counter is synthesized.

Test Plan:
Use DAS_CYCLES=10, ARR_CYCLES=4, SOFT_CYCLES=3 for all scenarios.
- Reset: rst held 5 cycles with key_down all 1 -> all pulses 0 and paused=0 throughout, and no pulse after deassertion.
- LEFT press at t, held 30 cycles -> mv_left high at t+1, t+11, t+15, t+19, t+23, t+27; mv_right never high. Release -> no further pulses.
- LEFT held in H_ARR, then RIGHT pressed at u -> mv_right at u+1, next mv_right at u+11, no mv_left after u. RIGHT released while LEFT still held at v -> mv_left at v+1, then at v+11.
- SPACE, UP, Z presses on 3 consecutive cycles -> hard_drop, rot_cw, rot_ccw each a single one-cycle pulse, on consecutive cycles. Their releases produce nothing.
- P press while LEFT held and repeating -> paused=1 and mv_left stays 0. Second P press -> paused=0, and mv_left stays 0 until LEFT is re-pressed.
- DOWN press at t, held 10 cycles -> feature on: soft_drop at t+1, t+4, t+7, t+10; feature off: t+1 only.

Source files
------------

// File: rtl/key_action_gen.sv
// Turns PS/2 decoder key events into one-cycle game action pulses, with DAS/ARR horizontal auto-repeat and a pause toggle.
// Optional macro KEY_ACTION_SOFT_REPEAT_EN: adds a periodic soft-drop repeat while DOWN is held.
module key_action_gen #(
  parameter int unsigned DAS_CYCLES  = 17000000,
  parameter int unsigned ARR_CYCLES  = 5000000,
  parameter int unsigned SOFT_CYCLES = 3000000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic         mv_left,
  output logic         mv_right,
  output logic         soft_drop,
  output logic         hard_drop,
  output logic         rot_cw,
  output logic         rot_ccw,
  output logic         paused
);

  localparam logic [8:0] K_LEFT  = 9'h16B;
  localparam logic [8:0] K_RIGHT = 9'h174;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_Z     = 9'h01A;
  localparam logic [8:0] K_SPACE = 9'h029;
  localparam logic [8:0] K_P     = 9'h04D;

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);
  localparam longint unsigned  MAX_CYC  =
    (DAS_CYCLES > ARR_CYCLES) ? ((DAS_CYCLES > SOFT_CYCLES) ? DAS_CYCLES : SOFT_CYCLES)
                              : ((ARR_CYCLES > SOFT_CYCLES) ? ARR_CYCLES : SOFT_CYCLES);

  if ((64'd1 << CNT_W) <= MAX_CYC) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_t;

  h_state_t         h_st, h_nxt;
  logic             dir, dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             left_nxt, right_nxt, soft_nxt;

  // Stage p0: decode the incoming event
  logic press_p0, left_press_p0, right_press_p0, down_press_p0, pause_nxt_p0;
  logic act_held, opp_held, opp_press;

  assign press_p0       = key_valid && key_down[last_change];
  assign left_press_p0  = press_p0 && (last_change == K_LEFT);
  assign right_press_p0 = press_p0 && (last_change == K_RIGHT);
  assign down_press_p0  = press_p0 && (last_change == K_DOWN);
  // Pause takes effect on the same edge that toggles it, so no pulse leaks out while paused=1.
  assign pause_nxt_p0   = paused ^ (press_p0 && (last_change == K_P));

  assign act_held  = dir ? key_down[K_RIGHT] : key_down[K_LEFT];
  assign opp_held  = dir ? key_down[K_LEFT]  : key_down[K_RIGHT];
  assign opp_press = dir ? left_press_p0     : right_press_p0;

  always_comb begin
    h_nxt     = h_st;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    if (pause_nxt_p0) begin
      h_nxt   = H_IDLE;
      cnt_nxt = '0;
    end else begin
      case (h_st)
        H_IDLE: begin
          if (left_press_p0) begin
            left_nxt = 1'b1;
            dir_nxt  = 1'b0;
            cnt_nxt  = '0;
            h_nxt    = H_DAS;
          end else if (right_press_p0) begin
            right_nxt = 1'b1;
            dir_nxt   = 1'b1;
            cnt_nxt   = '0;
            h_nxt     = H_DAS;
          end
        end
        default: begin
          // Opposite press, or falling back to a still-held opposite key, restarts DAS the other way.
          if (opp_press || (!act_held && opp_held)) begin
            dir_nxt   = ~dir;
            left_nxt  = dir;
            right_nxt = ~dir;
            cnt_nxt   = '0;
            h_nxt     = H_DAS;
          end else if (!act_held) begin
            cnt_nxt = '0;
            h_nxt   = H_IDLE;
          end else if (cnt == ((h_st == H_DAS) ? DAS_LAST : ARR_LAST)) begin
            left_nxt  = ~dir;
            right_nxt = dir;
            cnt_nxt   = '0;
            h_nxt     = H_ARR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef KEY_ACTION_SOFT_REPEAT_EN
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

  logic [CNT_W-1:0] soft_cnt, soft_cnt_nxt;
  logic             soft_act, soft_act_nxt;

  // Repeat only follows a fresh DOWN press; unpause or reset with DOWN held stays quiet.
  always_comb begin
    soft_nxt     = 1'b0;
    soft_cnt_nxt = soft_cnt;
    soft_act_nxt = soft_act;
    if (pause_nxt_p0 || !key_down[K_DOWN]) begin
      soft_cnt_nxt = '0;
      soft_act_nxt = 1'b0;
    end else if (down_press_p0) begin
      soft_nxt     = 1'b1;
      soft_cnt_nxt = '0;
      soft_act_nxt = 1'b1;
    end else if (soft_act && (soft_cnt == SOFT_LAST)) begin
      soft_nxt     = 1'b1;
      soft_cnt_nxt = '0;
    end else if (soft_act) begin
      soft_cnt_nxt = soft_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_cnt <= '0;
      soft_act <= 1'b0;
    end else begin
      soft_cnt <= soft_cnt_nxt;
      soft_act <= soft_act_nxt;
    end
  end
`else
  assign soft_nxt = down_press_p0 && !pause_nxt_p0;
`endif

  // Stage p1: registered state and action pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_st      <= H_IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      paused    <= 1'b0;
      mv_left   <= 1'b0;
      mv_right  <= 1'b0;
      soft_drop <= 1'b0;
      hard_drop <= 1'b0;
      rot_cw    <= 1'b0;
      rot_ccw   <= 1'b0;
    end else begin
      h_st      <= h_nxt;
      dir       <= dir_nxt;
      cnt       <= cnt_nxt;
      paused    <= pause_nxt_p0;
      mv_left   <= left_nxt;
      mv_right  <= right_nxt;
      soft_drop <= soft_nxt;
      hard_drop <= press_p0 && (last_change == K_SPACE) && !pause_nxt_p0;
      rot_cw    <= press_p0 && (last_change == K_UP)    && !pause_nxt_p0;
      rot_ccw   <= press_p0 && (last_change == K_Z)     && !pause_nxt_p0;
    end
  end

endmodule

// File: tb/tb_key_action_gen.sv
// Directed bench for key_action_gen with DAS=10, ARR=4, SOFT=3; expectations are hand-derived cycle offsets.
module tb_key_action_gen;

  localparam logic [8:0] K_LEFT  = 9'h16B;
  localparam logic [8:0] K_RIGHT = 9'h174;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_Z     = 9'h01A;
  localparam logic [8:0] K_SPACE = 9'h029;
  localparam logic [8:0] K_P     = 9'h04D;

  // Output vector order: {mv_left, mv_right, soft_drop, hard_drop, rot_cw, rot_ccw, paused}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_L    = 7'b1000000;
  localparam logic [6:0] O_R    = 7'b0100000;
  localparam logic [6:0] O_SD   = 7'b0010000;
  localparam logic [6:0] O_HD   = 7'b0001000;
  localparam logic [6:0] O_CW   = 7'b0000100;
  localparam logic [6:0] O_CCW  = 7'b0000010;
  localparam logic [6:0] O_P    = 7'b0000001;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         mv_left, mv_right, soft_drop, hard_drop, rot_cw, rot_ccw, paused;
  logic [6:0]   outs;

  int n_checks = 0;
  int n_fail   = 0;

  key_action_gen #(
    .DAS_CYCLES (10),
    .ARR_CYCLES (4),
    .SOFT_CYCLES(3),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid),
    .mv_left    (mv_left),
    .mv_right   (mv_right),
    .soft_drop  (soft_drop),
    .hard_drop  (hard_drop),
    .rot_cw     (rot_cw),
    .rot_ccw    (rot_ccw),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  assign outs = {mv_left, mv_right, soft_drop, hard_drop, rot_cw, rot_ccw, paused};

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [8:0] code);
    key_down[code] = 1'b1;
    last_change    = code;
    key_valid      = 1'b1;
    tick();
    key_valid      = 1'b0;
  endtask

  task automatic release_key(input logic [8:0] code);
    key_down[code] = 1'b0;
    last_change    = code;
    key_valid      = 1'b1;
    tick();
    key_valid      = 1'b0;
  endtask

  task automatic hold_check(input string tag, input int n, input logic [6:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, outs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    key_down    = '1;
    last_change = K_LEFT;
    key_valid   = 1'b1;

    // Reset held with every key down and a live strobe
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_hold", outs, O_NONE);
    end
    rst       = 1'b0;
    key_valid = 1'b0;
    hold_check("rst_deassert", 12, O_NONE);
    key_down = '0;
    tick();

    // LEFT held: pulses at 1, 11, 15, 19, 23, 27; release on the edge a repeat is due
    press(K_LEFT);
    check("left_first", outs, O_L);
    for (int k = 2; k <= 30; k++) begin
      tick();
      check("left_rep", outs, (k == 11 || k == 15 || k == 19 || k == 23 || k == 27) ? O_L : O_NONE);
    end
    release_key(K_LEFT);
    check("left_rel_prio", outs, O_NONE);
    hold_check("left_after_rel", 10, O_NONE);

    // RIGHT press
    press(K_RIGHT);
    check("right_first", outs, O_R);
    release_key(K_RIGHT);
    check("right_rel", outs, O_NONE);
    hold_check("right_idle", 12, O_NONE);

    // LEFT into ARR, RIGHT overrides, RIGHT release falls back to held LEFT
    press(K_LEFT);
    check("sw_left_first", outs, O_L);
    for (int k = 2; k <= 12; k++) begin
      tick();
      check("sw_left_rep", outs, (k == 11) ? O_L : O_NONE);
    end
    press(K_RIGHT);
    check("sw_right_first", outs, O_R);
    for (int k = 2; k <= 12; k++) begin
      tick();
      check("sw_right_rep", outs, (k == 11) ? O_R : O_NONE);
    end
    release_key(K_RIGHT);
    check("sw_back_left", outs, O_L);
    for (int k = 2; k <= 12; k++) begin
      tick();
      check("sw_back_rep", outs, (k == 11) ? O_L : O_NONE);
    end
    release_key(K_LEFT);
    check("sw_rel", outs, O_NONE);
    hold_check("sw_idle", 5, O_NONE);

    // Edge-only actions on consecutive cycles
    press(K_SPACE);
    check("hard_drop", outs, O_HD);
    press(K_UP);
    check("rot_cw", outs, O_CW);
    press(K_Z);
    check("rot_ccw", outs, O_CCW);
    tick();
    check("edge_after", outs, O_NONE);
    release_key(K_SPACE);
    check("rel_space", outs, O_NONE);
    release_key(K_UP);
    check("rel_up", outs, O_NONE);
    release_key(K_Z);
    check("rel_z", outs, O_NONE);
    hold_check("edge_idle", 3, O_NONE);

    // Pause while LEFT repeats; unpause needs a fresh LEFT press
    press(K_LEFT);
    check("pz_left_first", outs, O_L);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("pz_left_rep", outs, (k == 11 || k == 15) ? O_L : O_NONE);
    end
    press(K_P);
    check("pz_on", outs, O_P);
    hold_check("pz_held", 10, O_P);
    release_key(K_P);
    check("pz_rel_p", outs, O_P);
    hold_check("pz_still", 3, O_P);
    press(K_P);
    check("pz_off", outs, O_NONE);
    hold_check("pz_no_resume", 20, O_NONE);
    press(K_LEFT);
    check("pz_repress", outs, O_L);
    release_key(K_LEFT);
    check("pz_rel_left", outs, O_NONE);
    release_key(K_P);
    check("pz_rel_p2", outs, O_NONE);

    // DOWN held 10 cycles
    press(K_DOWN);
    check("soft_first", outs, O_SD);
    for (int k = 2; k <= 10; k++) begin
      tick();
`ifdef KEY_ACTION_SOFT_REPEAT_EN
      check("soft_rep", outs, ((k % 3) == 1) ? O_SD : O_NONE);
`else
      check("soft_rep", outs, O_NONE);
`endif
    end
    release_key(K_DOWN);
    check("soft_rel", outs, O_NONE);
    hold_check("soft_idle", 4, O_NONE);

    // Asynchronous reset mid-pulse with LEFT still held
    press(K_LEFT);
    check("ar_left_first", outs, O_L);
    rst = 1'b1;
    #1;
    check("ar_async", outs, O_NONE);
    tick();
    rst = 1'b0;
    hold_check("ar_no_pulse", 15, O_NONE);
    release_key(K_LEFT);
    check("ar_rel", outs, O_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
